// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - parametrised universal register: load, shifts and rotates, one bit per clock
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             sclr,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] pi,
    input  logic             sil,
    input  logic             sir,
    output logic [WIDTH-1:0] po,
    output logic             busy,
    output logic             done,
    output logic             so_l,
    output logic             so_r
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ASR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ROR  = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [2:0]       op;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] po_step;

    assign so_l = po[WIDTH-1];
    assign so_r = po[0];

    // Single-bit step of the latched op; serial fills are taken live each edge
    always_comb begin
        po_step = po;
        case (op)
            M_SHL:   po_step = {po[WIDTH-2:0], sir};
            M_SHR:   po_step = {sil, po[WIDTH-1:1]};
            M_ASR:   po_step = {po[WIDTH-1], po[WIDTH-1:1]};
            M_ROL:   po_step = {po[WIDTH-2:0], po[WIDTH-1]};
            M_ROR:   po_step = {po[0], po[WIDTH-1:1]};
            default: po_step = po;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            po    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
            op    <= M_HOLD;
            cnt   <= '0;
        end else if (sclr) begin
            po    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        case (mode)
                            M_LOAD: begin
                                po   <= pi;
                                done <= 1'b1;
                            end
                            M_SHL, M_SHR, M_ASR, M_ROL, M_ROR: begin
                                if (amt == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    op    <= mode;
                                    cnt   <= amt;
                                    busy  <= 1'b1;
                                    state <= RUN;
                                end
                            end
                            default: done <= 1'b1;
                        endcase
                    end
                end
                RUN: begin
                    po  <= po_step;
                    cnt <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed-vector bench for univ_shift_reg
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       sclr;
    logic       start;
    logic [2:0] mode;
    logic [3:0] amt;
    logic [7:0] pi;
    logic       sil;
    logic       sir;
    logic [7:0] po;
    logic       busy;
    logic       done;
    logic       so_l;
    logic       so_r;

    int n_vec = 0;
    int n_bad = 0;
    int cycles;

    univ_shift_reg #(.WIDTH(8), .AMT_W(4)) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .sclr (sclr),
        .start(start),
        .mode (mode),
        .amt  (amt),
        .pi   (pi),
        .sil  (sil),
        .sir  (sir),
        .po   (po),
        .busy (busy),
        .done (done),
        .so_l (so_l),
        .so_r (so_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, then counts busy cycles (bounded) until it clears
    task automatic run_op(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d);
        start = 1'b1; mode = m; amt = a; pi = d;
        tick();
        start = 1'b0;
        cycles = 0;
        while (busy && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        clr_n = 1'b0; sclr = 1'b0; start = 1'b0; mode = 3'b000;
        amt = 4'd0; pi = 8'h00; sil = 1'b0; sir = 1'b0;
        tick(); tick();
        chk("rst_po", po, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        clr_n = 1'b1;
        tick();

        // Async reset in the middle of a running shift
        run_op(3'b001, 4'd0, 8'hFF);
        start = 1'b1; mode = 3'b010; amt = 4'd10;
        tick();
        start = 1'b0;
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_po", po, 8'hFF);
        #3 clr_n = 1'b0;
        #1;
        chk("async_po", po, 8'h00);
        chk("async_busy", busy, 1'b0);
        chk("async_done", done, 1'b0);
        #2 clr_n = 1'b1;
        run_op(3'b000, 4'd0, 8'h00);
        chk("post_rst_hold_po", po, 8'h00);

        // LOAD then HOLD
        run_op(3'b001, 4'd0, 8'b10011010);
        chk("load_cycles", cycles, 0);
        chk("load_po", po, 8'h9A);
        chk("load_done", done, 1'b1);
        tick();
        chk("load_done_pulse", done, 1'b0);
        chk("load_busy", busy, 1'b0);
        run_op(3'b000, 4'd0, 8'h00);
        chk("hold_po", po, 8'h9A);
        chk("hold_done", done, 1'b1);

        // SHL by 3 with sir=1; a LOAD request mid-run must be ignored
        sir = 1'b1;
        start = 1'b1; mode = 3'b010; amt = 4'd3;
        tick();
        start = 1'b0;
        chk("shl_accept_po", po, 8'h9A);
        chk("shl_accept_busy", busy, 1'b1);
        chk("shl_accept_done", done, 1'b0);
        start = 1'b1; mode = 3'b001; pi = 8'h00;
        tick();
        chk("shl_s1_po", po, 8'h35);
        tick();
        start = 1'b0;
        chk("shl_s2_po", po, 8'h6B);
        chk("shl_s2_busy", busy, 1'b1);
        chk("shl_s2_done", done, 1'b0);
        tick();
        chk("shl_po", po, 8'hD7);
        chk("shl_busy", busy, 1'b0);
        chk("shl_done", done, 1'b1);
        chk("shl_so_l", so_l, 1'b1);
        chk("shl_so_r", so_r, 1'b1);
        sir = 1'b0;

        // ROR 4, ASR 2, ROL 8
        run_op(3'b001, 4'd0, 8'h9A);
        run_op(3'b110, 4'd4, 8'h00);
        chk("ror_cycles", cycles, 4);
        chk("ror_po", po, 8'hA9);
        chk("ror_done", done, 1'b1);
        run_op(3'b001, 4'd0, 8'h9A);
        run_op(3'b100, 4'd2, 8'h00);
        chk("asr_cycles", cycles, 2);
        chk("asr_po", po, 8'hE6);
        run_op(3'b001, 4'd0, 8'h9A);
        run_op(3'b101, 4'd8, 8'h00);
        chk("rol8_cycles", cycles, 8);
        chk("rol8_po", po, 8'h9A);
        chk("rol8_done", done, 1'b1);

        // SHR amt=0, then SHR 15 with sil=0
        run_op(3'b011, 4'd0, 8'h00);
        chk("shr0_cycles", cycles, 0);
        chk("shr0_busy", busy, 1'b0);
        chk("shr0_done", done, 1'b1);
        chk("shr0_po", po, 8'h9A);
        sil = 1'b0;
        run_op(3'b011, 4'd15, 8'h00);
        chk("shr15_cycles", cycles, 15);
        chk("shr15_po", po, 8'h00);
        chk("shr15_done", done, 1'b1);

        // sil sampled live: 1 on first step, 0 on second
        run_op(3'b001, 4'd0, 8'h9A);
        start = 1'b1; mode = 3'b011; amt = 4'd2;
        tick();
        start = 1'b0; sil = 1'b1;
        tick();
        chk("shr_live1_po", po, 8'hCD);
        sil = 1'b0;
        tick();
        chk("shr_live2_po", po, 8'h66);
        chk("shr_live_done", done, 1'b1);

        // Reserved mode behaves as HOLD
        run_op(3'b111, 4'd5, 8'h00);
        chk("rsv_cycles", cycles, 0);
        chk("rsv_po", po, 8'h66);
        chk("rsv_done", done, 1'b1);

        // sclr aborts a 5-step SHL at its second step
        run_op(3'b001, 4'd0, 8'h9A);
        start = 1'b1; mode = 3'b010; amt = 4'd5;
        tick();
        start = 1'b0;
        tick();
        chk("sclr_pre_po", po, 8'h34);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        chk("sclr_po", po, 8'h00);
        chk("sclr_busy", busy, 1'b0);
        chk("sclr_done", done, 1'b0);
        tick();
        chk("sclr_after_done", done, 1'b0);
        chk("sclr_after_po", po, 8'h00);
        run_op(3'b001, 4'd0, 8'h5C);
        chk("sclr_reload_po", po, 8'h5C);
        chk("sclr_reload_done", done, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
